// File: rtl/multi_edge_counter.sv
// Per-channel rising/falling edge counter with wrap/saturate, sticky overflow and edge pulses.
// Define EDGE_CNT_SYNC_EN to insert a 2-flop synchroniser per channel ahead of edge detection.
module multi_edge_counter #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [N_CH-1:0]         sig_in,
  output logic [N_CH*CNT_W-1:0]   rise_cnt,
  output logic [N_CH*CNT_W-1:0]   fall_cnt,
  output logic [N_CH-1:0]         rise_ovf,
  output logic [N_CH-1:0]         fall_ovf,
  output logic [N_CH-1:0]         rise_pulse,
  output logic [N_CH-1:0]         fall_pulse
);

  typedef enum logic [1:0] {ST_SYNC0, ST_SYNC1, ST_PRIME, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [N_CH-1:0]         sig_s;
  logic [N_CH-1:0]         sig_d_q, sig_d_d;
  logic [N_CH*CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
  logic [N_CH*CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic [N_CH-1:0]         rise_ovf_q, rise_ovf_d;
  logic [N_CH-1:0]         fall_ovf_q, fall_ovf_d;
  logic [N_CH-1:0]         rise_pulse_q, rise_pulse_d;
  logic [N_CH-1:0]         fall_pulse_q, fall_pulse_d;
  logic [N_CH-1:0]         rise_det, fall_det;
  logic                    primed;

`ifdef EDGE_CNT_SYNC_EN
  // Priming is deferred until both synchroniser stages carry post-reset samples.
  localparam state_t RST_STATE = ST_SYNC0;
  logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sig_s = sync2_q;
`else
  localparam state_t RST_STATE = ST_PRIME;
  assign sig_s = sig_in;
`endif

  // Returns {overflow, next_count} for one increment.
  function automatic logic [CNT_W:0] step(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] nxt;
    logic             at_max;
    at_max = (c == '1);
    nxt    = c + 1'b1;
    if (at_max && (SATURATE != 0)) nxt = c;
    return {at_max, nxt};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC0: state_d = ST_SYNC1;
      ST_SYNC1: state_d = ST_PRIME;
      ST_PRIME: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
    endcase
  end

  assign primed = (state_q == ST_RUN);

  always_comb begin
    logic [CNT_W:0] r_step;
    logic [CNT_W:0] f_step;
    r_step       = '0;
    f_step       = '0;
    sig_d_d      = sig_s;
    rise_det     = primed ? (sig_s & ~sig_d_q) : '0;
    fall_det     = primed ? (~sig_s & sig_d_q) : '0;
    rise_pulse_d = rise_det;
    fall_pulse_d = fall_det;
    rise_cnt_d   = rise_cnt_q;
    fall_cnt_d   = fall_cnt_q;
    rise_ovf_d   = rise_ovf_q;
    fall_ovf_d   = fall_ovf_q;
    if (clr) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
      rise_ovf_d = '0;
      fall_ovf_d = '0;
    end else if (en) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (rise_det[i]) begin
          r_step = step(rise_cnt_q[i*CNT_W +: CNT_W]);
          rise_cnt_d[i*CNT_W +: CNT_W] = r_step[CNT_W-1:0];
          if (r_step[CNT_W]) rise_ovf_d[i] = 1'b1;
        end
        if (fall_det[i]) begin
          f_step = step(fall_cnt_q[i*CNT_W +: CNT_W]);
          fall_cnt_d[i*CNT_W +: CNT_W] = f_step[CNT_W-1:0];
          if (f_step[CNT_W]) fall_ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RST_STATE;
      sig_d_q      <= '0;
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      rise_ovf_q   <= '0;
      fall_ovf_q   <= '0;
      rise_pulse_q <= '0;
      fall_pulse_q <= '0;
    end else begin
      state_q      <= state_d;
      sig_d_q      <= sig_d_d;
      rise_cnt_q   <= rise_cnt_d;
      fall_cnt_q   <= fall_cnt_d;
      rise_ovf_q   <= rise_ovf_d;
      fall_ovf_q   <= fall_ovf_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
    end
  end

  assign rise_cnt   = rise_cnt_q;
  assign fall_cnt   = fall_cnt_q;
  assign rise_ovf   = rise_ovf_q;
  assign fall_ovf   = fall_ovf_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;

endmodule

// File: tb/tb_multi_edge_counter.sv
// Directed bench for multi_edge_counter: wrapping DUT plus a saturating instance on shared inputs.
module tb_multi_edge_counter;

`ifdef EDGE_CNT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [3:0]  sig_in;
  logic [31:0] rise_cnt, fall_cnt, s_rise_cnt, s_fall_cnt;
  logic [3:0]  rise_ovf, fall_ovf, rise_pulse, fall_pulse;
  logic [3:0]  s_rise_ovf, s_fall_ovf, s_rise_pulse, s_fall_pulse;
  logic [23:0] upper;

  int errors = 0;
  int checks = 0;
  int rp_tot [4];
  int fp_tot [4];

  always #5 clk = ~clk;

  multi_edge_counter #(.N_CH(4), .CNT_W(8), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_in(sig_in),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .rise_ovf(rise_ovf), .fall_ovf(fall_ovf),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  multi_edge_counter #(.N_CH(4), .CNT_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_in(sig_in),
    .rise_cnt(s_rise_cnt), .fall_cnt(s_fall_cnt), .rise_ovf(s_rise_ovf), .fall_ovf(s_fall_ovf),
    .rise_pulse(s_rise_pulse), .fall_pulse(s_fall_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rc(input int ch);
    return rise_cnt[ch*8 +: 8];
  endfunction

  function automatic logic [7:0] fc(input int ch);
    return fall_cnt[ch*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      rp_tot[c] += int'(rise_pulse[c]);
      fp_tot[c] += int'(fall_pulse[c]);
    end
  endtask

  task automatic clear_totals();
    for (int c = 0; c < 4; c++) begin
      rp_tot[c] = 0;
      fp_tot[c] = 0;
    end
  endtask

  // clr held long enough to swallow any edge still travelling through the sampling path
  task automatic do_clr();
    clr = 1'b1;
    repeat (LAT + 1) tick();
    clr = 1'b0;
    tick();
    clear_totals();
  endtask

  task automatic pulse_ch(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in[ch] = 1'b1;
      tick();
      sig_in[ch] = 1'b0;
      tick();
    end
    repeat (LAT) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_totals();
    rst = 1'b1; en = 1'b1; clr = 1'b0; sig_in = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rise_cnt", rise_cnt, 32'd0);
    chk("reset_fall_cnt", fall_cnt, 32'd0);
    chk("reset_flags", {16'd0, rise_ovf, fall_ovf, rise_pulse, fall_pulse}, 32'd0);

    // T1: level high through reset release must not count as a rise
    rst = 1'b0;
    repeat (5) tick();
    chk("t1_rise_ch0", 32'(rc(0)), 32'd0);
    chk("t1_rise_pulses", 32'(rp_tot[0]), 32'd0);

    sig_in = 4'b0000;
    do_clr();

    // T2: 10 full periods on ch0, 2 clks high / 2 clks low
    for (int p = 0; p < 10; p++) begin
      sig_in[0] = 1'b1;
      repeat (2) tick();
      sig_in[0] = 1'b0;
      repeat (2) tick();
    end
    repeat (LAT) tick();
    chk("t2_rise_ch0", 32'(rc(0)), 32'd10);
    chk("t2_fall_ch0", 32'(fc(0)), 32'd10);
    chk("t2_rise_pulses", 32'(rp_tot[0]), 32'd10);
    chk("t2_fall_pulses", 32'(fp_tot[0]), 32'd10);
    upper = rise_cnt[31:8];
    chk("t2_rise_ch123", 32'(upper), 32'd0);
    upper = fall_cnt[31:8];
    chk("t2_fall_ch123", 32'(upper), 32'd0);

    // T3: 255 rises is the last count without overflow; the 256th wraps or saturates
    do_clr();
    pulse_ch(2, 255);
    chk("t3_rise_ch2_255", 32'(rc(2)), 32'd255);
    chk("t3_ovf_ch2_pre", 32'(rise_ovf[2]), 32'd0);
    pulse_ch(2, 1);
    chk("t3_rise_ch2_wrap", 32'(rc(2)), 32'd0);
    chk("t3_rise_ovf_wrap", 32'(rise_ovf), 32'b0100);
    chk("t3_fall_ovf_wrap", 32'(fall_ovf), 32'b0100);
    chk("t3_sat_rise_ch2", 32'(s_rise_cnt[23:16]), 32'd255);
    chk("t3_sat_rise_ovf", 32'(s_rise_ovf), 32'b0100);

    // T4: edges while disabled are lost but still pulse
    do_clr();
    en = 1'b0;
    pulse_ch(1, 3);
    en = 1'b1;
    pulse_ch(1, 2);
    chk("t4_rise_ch1", 32'(rc(1)), 32'd2);
    chk("t4_fall_ch1", 32'(fc(1)), 32'd2);
    chk("t4_rise_pulses", 32'(rp_tot[1]), 32'd5);
    chk("t4_fall_pulses", 32'(fp_tot[1]), 32'd5);

    // T5: clr coincident with a rise discards it; next edge counts from 0
    do_clr();
    pulse_ch(3, 7);
    chk("t5_rise_ch3_7", 32'(rc(3)), 32'd7);
    sig_in[3] = 1'b1;
    repeat (LAT - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_rise_ch3", 32'(rc(3)), 32'd0);
    chk("t5_clr_ovf", 32'({rise_ovf, fall_ovf}), 32'd0);
    chk("t5_clr_pulse", 32'(rise_pulse[3]), 32'd1);
    sig_in[3] = 1'b0;
    repeat (LAT + 1) tick();
    sig_in[3] = 1'b1;
    repeat (LAT - 1) tick();
    chk("t5_latency_pre", 32'(rc(3)), 32'd0);
    tick();
    chk("t5_latency_cnt", 32'(rc(3)), 32'd1);
    chk("t5_latency_pulse", 32'(rise_pulse[3]), 32'd1);
    sig_in[3] = 1'b0;
    repeat (LAT + 1) tick();

    // T6: asynchronous reset mid-count, then re-prime with a high level
    do_clr();
    pulse_ch(0, 37);
    chk("t6_rise_ch0_37", 32'(rc(0)), 32'd37);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_rise", rise_cnt, 32'd0);
    chk("t6_async_fall", fall_cnt, 32'd0);
    sig_in[0] = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t6_reprime_rise", 32'(rc(0)), 32'd0);
    pulse_ch(0, 1);
    chk("t6_post_fall", 32'(fc(0)), 32'd1);
    chk("t6_post_rise", 32'(rc(0)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
